// File: rtl/mmio_timer_periph.sv
// mmio_timer_periph
// Memory-mapped peripheral on the CPU data-memory bus. The MEM stage is the
// initiator. Reads are combinational (same-cycle data) and writes commit on
// the rising clock edge.
//
// Register window (32 bytes at BASE_ADDR, word index = Address[4:2]):
//   0x00 TH      reload value, RW
//   0x04 TL      count, RW
//   0x08 TCON    bit0 EN, bit1 IEN, bit2 STAT (write 1 to clear)
//   0x0C LED     [7:0], RW
//   0x10 DIGI    [DIGI_W-1:0], RW
//   0x14 SYSTICK free-running cycle counter, RO
//   0x18 PRESC   [15:0], RW when TIMER_PRESCALE_EN is defined, else reserved
//   0x1C         reserved, reads 0
//
// Optional feature macro: TIMER_PRESCALE_EN (adds the TL prescaler).
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   Address    byte address from the MEM stage
//   Write_data store data
//   MemRead    load strobe
//   MemWrite   store strobe
//   Mem_data   load data, combinational, 0 when not selected
//   hit        Address falls inside the register window
//   irq        timer interrupt request (STAT & IEN), level
//   led        LED register
//   digi       digit/segment register
module mmio_timer_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          DIGI_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Address,
  input  logic [31:0]       Write_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [31:0]       Mem_data,
  output logic              hit,
  output logic              irq,
  output logic [7:0]        led,
  output logic [DIGI_W-1:0] digi
);

  localparam logic [2:0] W_TH      = 3'd0;
  localparam logic [2:0] W_TL      = 3'd1;
  localparam logic [2:0] W_TCON    = 3'd2;
  localparam logic [2:0] W_LED     = 3'd3;
  localparam logic [2:0] W_DIGI    = 3'd4;
  localparam logic [2:0] W_SYSTICK = 3'd5;
`ifdef TIMER_PRESCALE_EN
  localparam logic [2:0] W_PRESC   = 3'd6;
`endif

  logic [31:0]       th_reg, th_next;
  logic [31:0]       tl_reg, tl_next;
  logic              en_reg, en_next;
  logic              ien_reg, ien_next;
  logic              stat_reg, stat_next;
  logic [7:0]        led_reg, led_next;
  logic [DIGI_W-1:0] digi_reg, digi_next;
  logic [31:0]       systick_reg;

  logic [2:0] word_sel;
  logic       wr;
  logic       wr_tl;
  logic       wr_tcon;
  logic       tl_step;
  logic       overflow;

  // Byte-lane bits carry no meaning for word-wide registers.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, Address[1:0]};

  assign hit      = (Address[31:5] == BASE_ADDR[31:5]);
  assign word_sel = Address[4:2];
  assign wr       = hit & MemWrite;
  assign wr_tl    = wr & (word_sel == W_TL);
  assign wr_tcon  = wr & (word_sel == W_TCON);

`ifdef TIMER_PRESCALE_EN
  logic [15:0] presc_reg, presc_next;
  logic [15:0] pcnt_reg, pcnt_next;
  logic        wr_presc;

  assign wr_presc = wr & (word_sel == W_PRESC);
  // TL only advances on the cycle the prescale counter reaches PRESC.
  assign tl_step  = en_reg & (pcnt_reg == presc_reg);

  always_comb begin
    presc_next = presc_reg;
    pcnt_next  = pcnt_reg;
    if (wr_presc) begin
      presc_next = Write_data[15:0];
    end
    // Reprogramming the prescaler or the timer control restarts the divider.
    if (wr_presc || wr_tcon) begin
      pcnt_next = 16'h0;
    end else if (en_reg) begin
      pcnt_next = tl_step ? 16'h0 : pcnt_reg + 16'h1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_reg <= 16'h0;
      pcnt_reg  <= 16'h0;
    end else begin
      presc_reg <= presc_next;
      pcnt_reg  <= pcnt_next;
    end
  end
`else
  assign tl_step = en_reg;
`endif

  assign overflow = tl_step & (tl_reg == 32'hFFFF_FFFF);

  always_comb begin
    th_next   = th_reg;
    tl_next   = tl_reg;
    en_next   = en_reg;
    ien_next  = ien_reg;
    stat_next = stat_reg;
    led_next  = led_reg;
    digi_next = digi_reg;

    // Reload uses the current TH even if TH is being written this cycle.
    if (tl_step) begin
      tl_next = overflow ? th_reg : tl_reg + 32'h1;
    end

    if (wr) begin
      case (word_sel)
        W_TH:    th_next   = Write_data;
        W_TL:    tl_next   = Write_data;
        W_TCON: begin
          en_next  = Write_data[0];
          ien_next = Write_data[1];
          if (Write_data[2]) begin
            stat_next = 1'b0;
          end
        end
        W_LED:   led_next  = Write_data[7:0];
        W_DIGI:  digi_next = Write_data[DIGI_W-1:0];
        default: ;
      endcase
    end

    // Overflow set beats a simultaneous clear; a software TL write
    // pre-empts the overflow entirely.
    if (overflow && ien_reg && !wr_tl) begin
      stat_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_reg      <= 32'h0;
      tl_reg      <= 32'h0;
      en_reg      <= 1'b0;
      ien_reg     <= 1'b0;
      stat_reg    <= 1'b0;
      led_reg     <= 8'h0;
      digi_reg    <= '0;
      systick_reg <= 32'h0;
    end else begin
      th_reg      <= th_next;
      tl_reg      <= tl_next;
      en_reg      <= en_next;
      ien_reg     <= ien_next;
      stat_reg    <= stat_next;
      led_reg     <= led_next;
      digi_reg    <= digi_next;
      systick_reg <= systick_reg + 32'h1;
    end
  end

  always_comb begin
    Mem_data = 32'h0;
    if (hit && MemRead) begin
      case (word_sel)
        W_TH:      Mem_data = th_reg;
        W_TL:      Mem_data = tl_reg;
        W_TCON:    Mem_data = {29'h0, stat_reg, ien_reg, en_reg};
        W_LED:     Mem_data = {24'h0, led_reg};
        W_DIGI:    Mem_data = {{(32-DIGI_W){1'b0}}, digi_reg};
        W_SYSTICK: Mem_data = systick_reg;
`ifdef TIMER_PRESCALE_EN
        W_PRESC:   Mem_data = {16'h0, presc_reg};
`endif
        default:   Mem_data = 32'h0;
      endcase
    end
  end

  assign irq  = stat_reg & ien_reg;
  assign led  = led_reg;
  assign digi = digi_reg;

endmodule

// File: doc/mmio_timer_periph.md
Name: mmio_timer_periph

Overview:
- Memory-mapped peripheral responder on the CPU data-memory bus; the CPU MEM stage is the initiator.
- Sits beside the data memory. The top level routes the bus here when `hit` is 1 and muxes `Mem_data` back to the CPU.
- Provides a reloadable 32-bit timer with an interrupt, LED and 7-segment output registers, and a free-running systick counter.
- Reads are combinational, returning data in the same cycle as the MEM stage. Writes commit on the clock edge.

Parameters:
- BASE_ADDR, 32'h4000_0000, base of the 32-byte register window. Bits [4:0] must be 0.
- DIGI_W, 12, width of the digit/segment output register.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- Address  input  32  byte address from the MEM stage.
- Write_data  input  32  store data.
- MemRead  input  1  load strobe.
- MemWrite  input  1  store strobe.
- Mem_data  output  32  load data, combinational.
- hit  output  1  Address[31:5] == BASE_ADDR[31:5], combinational.
- irq  output  1  timer interrupt request, level.
- led  output  8  LED register.
- digi  output  DIGI_W  digit/segment register.

Behaviour:
- Register map (offset = Address[4:0]; Address[1:0] is ignored, so word index = Address[4:2]):
  - 0x00 TH: reload value, RW.
  - 0x04 TL: count, RW.
  - 0x08 TCON: bit0 EN, bit1 IEN, bit2 STAT; upper bits read 0.
  - 0x0C LED: [7:0], RW.
  - 0x10 DIGI: [DIGI_W-1:0], RW.
  - 0x14 SYSTICK: RO; writes are ignored.
  - 0x18 and 0x1C: reserved, read 0, writes ignored.
- Reset (reset=0, asynchronous): TH, TL, TCON, LED, DIGI and SYSTICK all clear to 0, so irq=0, led=0, digi=0. Reset asserted mid-count aborts the count immediately; no overflow is recorded.
- Reads:
  - Mem_data = selected register when hit & MemRead, else 32'h0. Zero latency.
  - Narrow registers are zero-extended.
- Writes: take effect at the clock edge when hit & MemWrite. MemWrite with hit=0 changes nothing.
- SYSTICK: increments by 1 every cycle out of reset. Wraps 32'hFFFF_FFFF -> 0.
- Timer, per cycle:
  - EN=0: TL holds.
  - EN=1 and TL != 32'hFFFF_FFFF: TL <= TL+1.
  - EN=1 and TL == 32'hFFFF_FFFF: TL <= TH, and STAT <= 1 if IEN=1. This is the overflow event.
  - If TH = 32'hFFFF_FFFF, an overflow occurs every cycle.
- TCON write:
  - EN and IEN take Write_data[1:0].
  - STAT is write-1-to-clear: Write_data[2]=1 clears it, 0 leaves it unchanged.
  - Software cannot set STAT.
- irq = STAT & IEN, registered-state derived with no combinational path from the bus. Clearing IEN masks irq without clearing STAT.
- Simultaneous events:
  - Software write to TL in the same cycle as an increment or overflow: the written value wins, and STAT is not set that cycle.
  - STAT-clear write in the same cycle as an overflow with IEN=1: set wins, STAT=1.
  - Write to TH in the same cycle as an overflow: the reload uses the old TH; the new TH applies from the next overflow.
- MemRead and MemWrite both 1: the read returns pre-write data; the write commits at the edge.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- Defined:
  - Offset 0x18 becomes PRESC, RW [15:0], reset 0.
  - An internal 16-bit prescale counter, reset 0, increments while EN=1.
  - TL advances (including the overflow check) only in cycles where the prescale counter == PRESC; the prescale counter then returns to 0.
  - PRESC=0 gives one TL step per cycle.
  - A write to PRESC or TCON also clears the prescale counter.
- Not defined: 0x18 is reserved (reads 0) and TL steps every enabled cycle.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release.
  - Expect led=0, digi=0, irq=0, and TH/TL/TCON reads = 0.
  - SYSTICK reads 1 exactly one cycle after the first post-reset edge, then 2.
- Register RW:
  - Write LED=32'h1A5 -> led=8'hA5 and read returns 32'hA5.
  - Write DIGI=32'hFFFF_F3C7 -> digi=12'h3C7.
  - Write SYSTICK -> value unchanged.
  - Address 0x4000_0020 -> hit=0 and read returns 0.
- Overflow/reload: TH=32'hFFFF_FFF0, TL=32'hFFFF_FFFD, TCON=3.
  - Expect STAT=1 and irq=1 on the 3rd enabled edge; TL reads FFFF_FFF0, then FFFF_FFF1.
  - Write TCON=32'h7 -> irq stays 0 until the next overflow 16 cycles later.
- Simultaneous:
  - STAT-clear write on the overflow cycle -> irq remains 1.
  - TL write of 5 on the overflow cycle -> TL=5, STAT unchanged.
- Async reset mid-count: assert reset=0 between edges while TL=0x1234, EN=1.
  - Expect TL, TCON, led and irq to go 0 before the next clk edge.
- TIMER_PRESCALE_EN: PRESC=3, TL=0, TCON=1.
  - Expect TL=1 after 4 edges and TL=2 after 8 edges.
  - With the macro undefined, 0x18 reads 0.
